// File: rtl/rle_tx_arbiter.sv
// Round-robin arbiter and framed serializer that shares one txd line between two RLE channels.
// Optional build macro: RLE_ARB_PARITY_EN adds an even parity bit over {id, data} before the stop bit.
module rle_tx_arbiter #(
  parameter int BIT_CYCLES = 1,
  parameter int GAP_BITS   = 1
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       dav0_,
  input  logic [7:0] data0,
  output logic       rfd0,
  input  logic       dav1_,
  input  logic [7:0] data1,
  output logic       rfd1,
  output logic       txd,
  output logic       busy
);

`ifdef RLE_ARB_PARITY_EN
  localparam int FRAME_BITS = 12;
`else
  localparam int FRAME_BITS = 11;
`endif
  // The start bit is driven directly at capture; the shift register holds the rest of the frame.
  localparam int SR_W      = FRAME_BITS - 1;
  localparam int GAP_TOTAL = GAP_BITS * BIT_CYCLES;

  localparam logic [15:0] CYC_LAST = 16'(BIT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'((GAP_TOTAL > 0) ? GAP_TOTAL - 1 : 0);
  localparam logic [3:0]  BIT_LAST = 4'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, ACK} state_t;

  state_t          state;
  logic            last;
  logic            gnt;
  logic [SR_W-1:0] shreg;
  logic [3:0]      bit_cnt;
  logic [15:0]     cyc_cnt;
  logic [15:0]     gap_cnt;

  logic            req_any;
  logic            pick;
  logic [7:0]      pick_data;
  logic [SR_W-1:0] load_word;
  logic            gnt_dav_;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_any = ~dav0_ | ~dav1_;
    pick    = 1'b0;
    if (~dav0_ & ~dav1_) begin
      pick = ~last;
    end else if (dav0_) begin
      pick = 1'b1;
    end
    pick_data = pick ? data1 : data0;
`ifdef RLE_ARB_PARITY_EN
    load_word = {1'b1, ^{pick, pick_data}, pick_data, pick};
`else
    load_word = {1'b1, pick_data, pick};
`endif
    gnt_dav_ = gnt ? dav1_ : dav0_;
  end

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state   <= IDLE;
      txd     <= 1'b1;
      rfd0    <= 1'b1;
      rfd1    <= 1'b1;
      busy    <= 1'b0;
      last    <= 1'b1;
      gnt     <= 1'b0;
      shreg   <= '1;
      bit_cnt <= '0;
      cyc_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            gnt     <= pick;
            last    <= pick;
            shreg   <= load_word;
            txd     <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            if (pick) rfd1 <= 1'b0;
            else      rfd0 <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              txd     <= 1'b1;
              gap_cnt <= '0;
              if (GAP_TOTAL == 0) state <= ACK;
              else                state <= GAP;
            end else begin
              // Shifting in ones leaves the line at mark once the stop bit has gone out.
              txd     <= shreg[0];
              shreg   <= {1'b1, shreg[SR_W-1:1]};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= ACK;
          else                     gap_cnt <= gap_cnt + 16'd1;
        end
        ACK: begin
          if (gnt_dav_) begin
            if (gnt) rfd1 <= 1'b1;
            else     rfd0 <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
